// File: rtl/traffic_queue_sim.sv
// Closed-loop traffic model for the stoplight controller: per-approach car queues fed by
// arrival pulses and drained at a fixed green headway. Optional macro: TRAFFIC_QUEUE_CONFLICT_CHECK_EN.
module traffic_queue_sim #(
    parameter int CW            = 4,
    parameter int DEPART_CYCLES = 4,
    parameter int SW            = 16
) (
    input  logic            CLK,
    input  logic            rst,
    input  logic [7:0]      arrive,
    input  logic [1:0]      north,
    input  logic [1:0]      south,
    input  logic [1:0]      east,
    input  logic [1:0]      west,
    input  logic [1:0]      northLeft,
    input  logic [1:0]      southLeft,
    input  logic [1:0]      eastLeft,
    input  logic [1:0]      westLeft,
    output logic            n_presence,
    output logic            s_presence,
    output logic            e_presence,
    output logic            w_presence,
    output logic            nl_presence,
    output logic            sl_presence,
    output logic            el_presence,
    output logic            wl_presence,
    output logic [8*CW-1:0] q_counts,
    output logic [7:0]      overflow,
    output logic [SW-1:0]   served_total,
    output logic            conflict
);

    localparam logic [7:0]    HW_LAST = 8'(DEPART_CYCLES - 1);
    localparam logic [CW-1:0] Q_MAX   = '1;
    localparam logic [CW-1:0] Q_ONE   = CW'(1);

    logic [1:0]    light [8];
    logic [7:0]    green;
    logic [7:0]    dep_evt;
    logic [7:0]    dep;
    logic [3:0]    dep_cnt;
    logic [CW-1:0] q  [8];
    logic [7:0]    hw [8];

    // Approach index order matches the arrive bit map: n, s, e, w, nl, sl, el, wl.
    assign light[0] = north;
    assign light[1] = south;
    assign light[2] = east;
    assign light[3] = west;
    assign light[4] = northLeft;
    assign light[5] = southLeft;
    assign light[6] = eastLeft;
    assign light[7] = westLeft;

    always_comb begin
        green   = '0;
        dep_evt = '0;
        dep     = '0;
        dep_cnt = '0;
        for (int i = 0; i < 8; i++) begin
            green[i]   = (light[i] == 2'b10);
            dep_evt[i] = green[i] && (hw[i] == HW_LAST);
            // A headway wrap on an empty queue is simply lost.
            dep[i]     = dep_evt[i] && (q[i] != '0);
            dep_cnt    = dep_cnt + {3'd0, dep[i]};
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                q[i]  <= '0;
                hw[i] <= '0;
            end
            overflow     <= '0;
            served_total <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (!green[i])
                    hw[i] <= '0;
                else if (dep_evt[i])
                    hw[i] <= '0;
                else
                    hw[i] <= hw[i] + 8'd1;

                // Arrival and departure together cancel, so a full queue never overflows here.
                if (arrive[i] && !dep[i]) begin
                    if (q[i] == Q_MAX)
                        overflow[i] <= 1'b1;
                    else
                        q[i] <= q[i] + Q_ONE;
                end else if (dep[i] && !arrive[i]) begin
                    q[i] <= q[i] - Q_ONE;
                end
            end
            served_total <= served_total + SW'(dep_cnt);
        end
    end

    genvar g;
    generate
        for (g = 0; g < 8; g++) begin : g_pack
            assign q_counts[g*CW +: CW] = q[g];
        end
    endgenerate

    assign n_presence  = (q[0] != '0);
    assign s_presence  = (q[1] != '0);
    assign e_presence  = (q[2] != '0);
    assign w_presence  = (q[3] != '0);
    assign nl_presence = (q[4] != '0);
    assign sl_presence = (q[5] != '0);
    assign el_presence = (q[6] != '0);
    assign wl_presence = (q[7] != '0);

`ifdef TRAFFIC_QUEUE_CONFLICT_CHECK_EN
    logic ns_green;
    logic ew_green;
    logic conflict_r;

    assign ns_green = green[0] | green[1] | green[4] | green[5];
    assign ew_green = green[2] | green[3] | green[6] | green[7];

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            conflict_r <= 1'b0;
        end else if (ns_green && ew_green) begin
            conflict_r <= 1'b1;
`ifndef SYNTHESIS
            if (!conflict_r)
                $display("traffic_queue_sim: conflicting greens detected at time %0t", $time);
`endif
        end
    end

    assign conflict = conflict_r;
`else
    assign conflict = 1'b0;
`endif

endmodule

// File: doc/traffic_queue_sim.md
Name: traffic_queue_sim

Overview:
- Closed-loop traffic model that sits opposite the stoplight controller (top_level): consumes its eight 2-bit light outputs and drives its eight *_presence inputs.
- Keeps one waiting-car queue per approach; cars are added by arrival pulses and removed at a fixed headway while that approach's light is green.
- Lets benches and FPGA demos exercise the controller with realistic, self-clearing demand instead of hand-driven presence levels.

Parameters:
- CW, 4, width of each queue counter (max queue 2^CW-1).
- DEPART_CYCLES, 4, green cycles per departed car (headway); legal range 1..255.
- SW, 16, width of served_total counter.

Ports:
- CLK  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- arrive  in  8  one-cycle arrival pulses; bit map 0=n,1=s,2=e,3=w,4=nl,5=sl,6=el,7=wl.
- north, south, east, west  in  2 each  through-lane light.
- northLeft, southLeft, eastLeft, westLeft  in  2 each  left-turn light.
- n_presence, s_presence, e_presence, w_presence  out  1 each  through-lane queue non-empty.
- nl_presence, sl_presence, el_presence, wl_presence  out  1 each  left-lane queue non-empty.
- q_counts  out  8*CW  packed queue depths; approach i at [i*CW +: CW].
- overflow  out  8  sticky per-approach arrival-dropped flag.
- served_total  out  SW  total departures, wraps modulo 2^SW.
- conflict  out  1  sticky conflicting-green flag (optional feature; tied 0 when compiled out).

Behaviour:
- Light encoding: 2'b00 red, 2'b01 yellow, 2'b10 green, 2'b11 treated as red. Departures only on green.
- Reset (async, immediate): all queues 0, all headway counters 0, overflow=0, served_total=0, conflict=0; all presence outputs 0.
- Per approach i, per cycle:
  - hw[i] (8 bit): light green → hw increments; when hw==DEPART_CYCLES-1 it wraps to 0 and raises dep_evt[i]. Light not green → hw forced to 0.
  - Departure happens only if dep_evt[i] && q[i]!=0. Empty queue: event discarded, hw still wraps.
  - Arrival happens if arrive[i]. Queue at 2^CW-1: arrival dropped, overflow[i] set (held until rst).
  - Simultaneous arrival and departure: q unchanged; departure still counts in served_total; overflow never set, even at full.
  - Otherwise q += arrival, q -= departure.
- First departure occurs on the DEPART_CYCLES-th consecutive green cycle. Going yellow/red mid-headway discards progress.
- Presence outputs = (q[i]!=0) decoded from registered q. Latency: arrival at edge k → presence high after edge k; last departure at edge k → presence low after edge k.
- served_total += popcount(actual departures this cycle), up to 8 per cycle; modulo wrap.
- Light inputs are sampled on the same edge as arrive; no internal synchronizer (same clock domain as the controller).
- rst asserted mid-operation clears everything immediately regardless of lights. Queues refill only via arrive.

Optional Feature:
- Macro TRAFFIC_QUEUE_CONFLICT_CHECK_EN.
- Defined: conflict goes high one cycle after any cycle in which an N/S-axis signal (north, south, northLeft, southLeft) is green at the same time as an E/W-axis signal (east, west, eastLeft, westLeft) is green. Sticky until rst. Under simulation it also issues $display with $time once, on the first set.
- Undefined: conflict tied to 1'b0; no checker logic.

Test Plan (CW=4, DEPART_CYCLES=4):
- rst=1, random arrive/lights -> all presences 0, q_counts=0, served_total=0; reset asserted asynchronously between edges clears outputs without waiting for CLK.
- 3 pulses on arrive[2], east held red -> q_e=3, e_presence=1. Then east=green -> departures on green cycles 4, 8, 12; e_presence falls after the 12th edge; served_total=3.
- q_n=2, north green for 3 cycles then yellow, then green again -> no departure in the first window; first departure on the 4th cycle of the second green.
- 16 arrivals on arrive[5], southLeft red -> q_sl=15, overflow[5]=1, other overflow bits 0. Then arrive[5] pulse coinciding with a departure at q=15 -> q stays 15, served_total +1.
- All eight approaches loaded with 1 car, all lights green simultaneously (macro defined) -> all queues empty on cycle 4, served_total=8, conflict=1. Macro undefined -> conflict stays 0.
- east green with empty queue for 10 cycles, then arrival on cycle 10 -> no underflow; q_e=1; departure on the next headway wrap (cycle 12).
